char_scroll_ctrl: RTL and testbench

- Sequencer that drives NUM_DISP 3-bit character codes into the team's existing 3-bit-to-7-segment character decoders, one decoder per HEX digit.
- Code map: 000=H, 001=E, 010=L, 011=O, 111=blank.
- Holds an 8-entry character message, scrolls it across the displays at a programmable tick rate, and supports load, run, pause and direction control.
- Sits between the board switches/keys and the per-digit decoder instances.

---
 rtl/char_scroll_ctrl.sv | 69 ++++++
 tb/tb_char_scroll_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/char_scroll_ctrl.sv
// char_scroll_ctrl: 8-character message scroller feeding per-digit 3-bit character decoders
//   CLOCK_50  in   system clock, rising edge
//   resetn    in   async active-low reset
//   run       in   1 = scroll, 0 = hold frame
//   dir       in   0 = left (offset+1), 1 = right (offset-1)
//   wr_en     in   message write strobe (accepted in IDLE/PAUSE only)
//   wr_addr   in   message slot
//   wr_data   in   character code
//   wr_ack    out  one-cycle pulse after an accepted write
//   codes     out  digit k code at [3k+2:3k], digit 0 leftmost
//   offset    out  scroll offset
//   state     out  00 IDLE, 01 RUN, 10 PAUSE
module char_scroll_ctrl #(
    parameter int NUM_DISP = 5,
    parameter int TICK_DIV = 50000000,
    parameter int MSG_LEN  = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [2:0]            wr_data,
    output logic                  wr_ack,
    output logic [3*NUM_DISP-1:0] codes,
    output logic [2:0]            offset,
    output logic [1:0]            state
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [23:0] DEF_MSG = {3'b111, 3'b111, 3'b111, 3'b011, 3'b010, 3'b010, 3'b001, 3'b000};
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} st_t;
    st_t st, st_nx;
    logic [CW-1:0] cnt;
    logic [2:0] msg [MSG_LEN];
    logic tick, wr_ok;
    assign tick  = st == RUN && cnt == CW'(TICK_DIV - 1);
    assign wr_ok = wr_en && st != RUN;
    assign state = st;
    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = run ? RUN : IDLE;
            RUN:     st_nx = run ? RUN : PAUSE;
            PAUSE:   st_nx = wr_en ? IDLE : run ? RUN : PAUSE;
            default: st_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            st     <= IDLE;
            cnt    <= '0;
            offset <= '0;
            wr_ack <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) msg[i] <= DEF_MSG[3*i +: 3];
        end else begin
            st     <= st_nx;
            wr_ack <= wr_ok;
            if (wr_ok) msg[wr_addr] <= wr_data;
            if (st == RUN) cnt <= tick ? '0 : cnt + CW'(1);
            else if (st == IDLE) cnt <= '0;
            if (tick) offset <= dir ? offset - 3'd1 : offset + 3'd1;
        end
    end
    for (genvar k = 0; k < NUM_DISP; k++) begin : g_dig
        // 3-bit sum wraps mod 8, so every index lands in the buffer
        assign codes[3*k +: 3] = msg[offset + 3'(k)];
    end
endmodule

// File: tb/tb_char_scroll_ctrl.sv
// tb_char_scroll_ctrl: randomized + directed check of char_scroll_ctrl against a behavioural model
module tb_char_scroll_ctrl;
    localparam int ND = 5;
    localparam int TD = 4;
    logic CLOCK_50 = 1'b0, resetn = 1'b0, run = 1'b0, dir = 1'b0, wr_en = 1'b0;
    logic [2:0] wr_addr = '0, wr_data = '0;
    logic wr_ack;
    logic [3*ND-1:0] codes;
    logic [2:0] offset;
    logic [1:0] state;
    int n_cmp = 0, n_bad = 0;
    int m_msg [8];
    int m_off, m_cnt, m_st, m_ack;
    char_scroll_ctrl #(.NUM_DISP(ND), .TICK_DIV(TD), .MSG_LEN(8)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .run(run), .dir(dir), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .codes(codes),
        .offset(offset), .state(state)
    );
    always #5 CLOCK_50 = ~CLOCK_50;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic m_reset();
        int d [8] = '{0, 1, 2, 2, 3, 7, 7, 7};
        m_msg = d;
        m_off = 0; m_cnt = 0; m_st = 0; m_ack = 0;
    endtask
    task automatic m_step(input int r, input int d, input int we, input int wa, input int wd);
        int nst;
        m_ack = (we != 0 && m_st != 1) ? 1 : 0;
        if (m_ack != 0) m_msg[wa] = wd;
        if (m_st == 1) begin
            if (m_cnt == TD - 1) begin
                m_cnt = 0;
                m_off = (m_off + (d != 0 ? 7 : 1)) % 8;
            end else m_cnt++;
        end else if (m_st == 0) m_cnt = 0;
        if (m_st == 0) nst = r != 0 ? 1 : 0;
        else if (m_st == 1) nst = r != 0 ? 1 : 2;
        else nst = we != 0 ? 0 : (r != 0 ? 1 : 2);
        m_st = nst;
    endtask
    function automatic logic [3*ND-1:0] exp_codes();
        logic [3*ND-1:0] v;
        for (int k = 0; k < ND; k++) v[3*k +: 3] = 3'(m_msg[(m_off + k) % 8]);
        return v;
    endfunction
    task automatic check_all(input string tag);
        check({tag, ".codes"}, 32'(codes), 32'(exp_codes()));
        check({tag, ".offset"}, 32'(offset), 32'(m_off));
        check({tag, ".state"}, 32'(state), 32'(m_st));
        check({tag, ".wr_ack"}, 32'(wr_ack), 32'(m_ack));
    endtask
    task automatic step(input string tag, input int r, input int d, input int we, input int wa, input int wd);
        run = r[0]; dir = d[0]; wr_en = we[0]; wr_addr = 3'(wa); wr_data = 3'(wd);
        @(posedge CLOCK_50);
        m_step(r, d, we, wa, wd);
        #1;
        check_all(tag);
    endtask
    initial begin
        m_reset();
        #12;
        check("rst.codes", 32'(codes), 32'({3'b011, 3'b010, 3'b010, 3'b001, 3'b000}));
        check("rst.offset", 32'(offset), 0);
        check("rst.state", 32'(state), 0);
        check("rst.wr_ack", 32'(wr_ack), 0);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) step("left", 1, 0, 0, 0, 0);
        check("off1", 32'(offset), 1);
        check("off1_codes", 32'(codes), 32'({3'b111, 3'b011, 3'b010, 3'b010, 3'b001}));
        for (int i = 0; i < 20; i++) step("left", 1, 0, 0, 0, 0);
        check("off6", 32'(offset), 6);
        check("off6_codes", 32'(codes), 32'({3'b010, 3'b001, 3'b000, 3'b111, 3'b111}));
        for (int i = 0; i < 8; i++) step("left", 1, 0, 0, 0, 0);
        check("wrap0", 32'(offset), 0);
        for (int i = 0; i < 4; i++) step("right", 1, 1, 0, 0, 0);
        check("off7", 32'(offset), 7);
        check("off7_codes", 32'(codes), 32'({3'b010, 3'b010, 3'b001, 3'b000, 3'b111}));
        for (int i = 0; i < 2; i++) step("pre_pause", 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("pause", 0, 1, 0, 0, 0);
        check("pause_state", 32'(state), 2);
        check("pause_off", 32'(offset), 7);
        step("resume", 1, 1, 0, 0, 0);
        check("resume_hold", 32'(offset), 7);
        step("resume", 1, 1, 0, 0, 0);
        check("resume_tick", 32'(offset), 6);
        step("wr_run", 1, 1, 1, 0, 3);
        check("wr_run_ack", 32'(wr_ack), 0);
        for (int i = 0; i < 10 && m_cnt != TD - 1; i++) step("to_tick", 1, 1, 0, 0, 0);
        step("tick_fall", 0, 1, 0, 0, 0);
        check("tick_fall_off", 32'(offset), 5);
        check("tick_fall_state", 32'(state), 2);
        step("wr_pause", 0, 1, 1, 0, 3);
        check("wr_pause_state", 32'(state), 0);
        check("wr_pause_ack", 32'(wr_ack), 1);
        check("wr_pause_dig3", 32'(codes[11:9]), 3);
        step("ack_drop", 0, 1, 0, 0, 0);
        check("ack_drop", 32'(wr_ack), 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(negedge CLOCK_50);
                resetn = 1'b0;
                #1;
                m_reset();
                check_all("async_rst");
                #2 resetn = 1'b1;
            end
            step("rand", int'($urandom_range(0, 5) != 0), int'($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
